// File: rtl/line_fill_word_sequencer_pkg.sv
// Shared types and constants for the cache line-fill word sequencer.
package line_fill_word_sequencer_pkg;

  // Default number of words in one cache line
  localparam int unsigned WORDS_PER_LINE = 8;

  // Sequencer modes: CPU write-hit decode, refill stepping, completion pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage : line_fill_word_sequencer_pkg

// File: rtl/line_fill_word_sequencer_if.sv
// Bus between CPU/refill path and the line-fill word sequencer.
interface line_fill_word_sequencer_if #(
  parameter int unsigned WORDS = line_fill_word_sequencer_pkg::WORDS_PER_LINE
);
  localparam int unsigned ADDR_W = $clog2(WORDS);

  logic [ADDR_W-1:0] cpu_word;
  logic              cpu_wr;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_word;
  logic              beat_valid;
  logic              beat_ready;
  logic              abort;
  logic [WORDS-1:0]  word_enable;
  logic [ADDR_W-1:0] cur_word;
  logic              busy;
  logic              fill_done;

  // Requester side: CPU and memory-refill path
  modport master (
    output cpu_word, cpu_wr, fill_start, fill_word, beat_valid, abort,
    input  beat_ready, word_enable, cur_word, busy, fill_done
  );

  // Sequencer side
  modport slave (
    input  cpu_word, cpu_wr, fill_start, fill_word, beat_valid, abort,
    output beat_ready, word_enable, cur_word, busy, fill_done
  );

endinterface : line_fill_word_sequencer_if

// File: rtl/line_fill_word_sequencer_word_onehot_dec.sv
// Combinational word index to one-hot enable decoder with gating enable.
module word_onehot_dec #(
  parameter int unsigned WORDS = 8
) (
  input  logic [$clog2(WORDS)-1:0] i_idx,
  input  logic                     i_en,
  output logic [WORDS-1:0]         o_onehot
);

  // One-hot of the index when enabled, otherwise all-zero
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot = WORDS'(1) << i_idx;
    end
  end

endmodule : word_onehot_dec

// File: rtl/line_fill_word_sequencer.sv
// Cache-line word-enable generator: CPU write-hit decode when idle,
// critical-word-first wrapping refill sequencing when filling.
module line_fill_word_sequencer
  import line_fill_word_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = WORDS_PER_LINE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  line_fill_word_sequencer_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(WORDS);

  fill_state_t       r_state;
  fill_state_t       w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_accept;
  logic              w_last_beat;
  logic              w_dec_en;
  logic [ADDR_W-1:0] w_dec_idx;
  logic [WORDS-1:0]  w_word_enable;
  logic              w_busy;
  logic              w_beat_ready;
  logic              w_fill_done;

  // Beat handshake; abort always wins over a presented beat
  assign w_accept    = (r_state == FILL) && bus.beat_valid && !bus.abort;
  assign w_last_beat = (r_cnt == ADDR_W'(WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.fill_start) begin
          w_next_state = FILL;
        end
      end
      FILL: begin
        if (bus.abort) begin
          w_next_state = IDLE;
        end else if (w_accept && w_last_beat) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Mode-dependent outputs and decoder source/enable selection
  always_comb begin
    w_busy       = 1'b0;
    w_beat_ready = 1'b0;
    w_fill_done  = 1'b0;
    w_dec_idx    = bus.cpu_word;
    w_dec_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_dec_idx = bus.cpu_word;
        w_dec_en  = bus.cpu_wr;
      end
      FILL: begin
        w_busy       = 1'b1;
        w_beat_ready = 1'b1;
        w_dec_idx    = r_ptr;
        w_dec_en     = w_accept;
      end
      DONE: begin
        w_fill_done = 1'b1;
      end
      default: begin
        w_dec_en = 1'b0;
      end
    endcase
  end

  // Refill word pointer and beat counter; both hold across abort until next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if ((r_state == IDLE) && bus.fill_start) begin
      r_ptr <= bus.fill_word;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  // Single shared decoder for both CPU and refill enables
  word_onehot_dec #(
    .WORDS (WORDS)
  ) u_dec (
    .i_idx    (w_dec_idx),
    .i_en     (w_dec_en),
    .o_onehot (w_word_enable)
  );

  // Drive the bus outputs
  assign bus.word_enable = w_word_enable;
  assign bus.cur_word    = r_ptr;
  assign bus.busy        = w_busy;
  assign bus.beat_ready  = w_beat_ready;
  assign bus.fill_done   = w_fill_done;

endmodule : line_fill_word_sequencer

// File: tb/tb_line_fill_word_sequencer.sv
// Scoreboard bench for line_fill_word_sequencer (WORDS=8 and WORDS=4 instances).
module tb_line_fill_word_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] en;
  } ev_t;

  ev_t q8[$];
  ev_t q4[$];
  ev_t e8;
  ev_t e4;

  line_fill_word_sequencer_if #(.WORDS(8)) a ();
  line_fill_word_sequencer_if #(.WORDS(4)) b ();

  line_fill_word_sequencer #(.WORDS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(a));
  line_fill_word_sequencer #(.WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input bit d, input logic [7:0] e);
    ev_t v;
    v.is_done = d;
    v.en      = e;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 8-word instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (a.word_enable !== 8'h00 || a.fill_done !== 1'b0)) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8: word_enable=%h fill_done=%b expected no output (t=%0t)",
                 a.word_enable, a.fill_done, $time);
      end else begin
        e8 = q8.pop_front();
        chk("ev8_enable", 32'(a.word_enable), e8.is_done ? 32'h0 : 32'(e8.en));
        chk("ev8_done", 32'(a.fill_done), 32'(e8.is_done));
      end
    end
  end

  // Monitor for the 4-word instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (b.word_enable !== 4'h0 || b.fill_done !== 1'b0)) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected4: word_enable=%h fill_done=%b expected no output (t=%0t)",
                 b.word_enable, b.fill_done, $time);
      end else begin
        e4 = q4.pop_front();
        chk("ev4_enable", 32'(b.word_enable), e4.is_done ? 32'h0 : 32'(e4.en));
        chk("ev4_done", 32'(b.fill_done), 32'(e4.is_done));
      end
    end
  end

  task automatic start8(input logic [2:0] w);
    a.fill_start = 1'b1;
    a.fill_word  = w;
    cyc();
    a.fill_start = 1'b0;
  endtask

  // Beats starting at word w; expected enables from a wrapping one-hot model
  task automatic beats8(input logic [2:0] w, input int n);
    logic [2:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = w + 3'(i);
      a.beat_valid = 1'b1;
      q8.push_back(mk(1'b0, 8'(1) << idx));
      cyc();
    end
    a.beat_valid = 1'b0;
  endtask

  logic [7:0] exp2 [8];
  logic [3:0] exp4 [4];
  int         n;
  bit         t;

  initial begin
    exp2 = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    exp4 = '{4'h8, 4'h1, 4'h2, 4'h4};
    {a.cpu_word, a.cpu_wr, a.fill_start, a.fill_word, a.beat_valid, a.abort} = '0;
    {b.cpu_word, b.cpu_wr, b.fill_start, b.fill_word, b.beat_valid, b.abort} = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_busy8",   32'(a.busy), 0);
    chk("rst_ready8",  32'(a.beat_ready), 0);
    chk("rst_cur8",    32'(a.cur_word), 0);
    chk("rst_done8",   32'(a.fill_done), 0);
    chk("rst_en8",     32'(a.word_enable), 0);
    chk("rst_busy4",   32'(b.busy), 0);
    chk("rst_en4",     32'(b.word_enable), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Idle decode, zero latency, dropped when cpu_wr falls
    a.cpu_wr = 1'b1;
    a.cpu_word = 3'd5;
    q8.push_back(mk(1'b0, 8'h20));
    #1 chk("idle_dec5", 32'(a.word_enable), 32'h20);
    cyc();
    a.cpu_wr = 1'b0;
    #1 chk("idle_wr0", 32'(a.word_enable), 0);
    cyc();

    // Fill from word 6 back-to-back; cpu_wr with fill_start still decodes
    a.cpu_wr = 1'b1;
    a.cpu_word = 3'd2;
    q8.push_back(mk(1'b0, 8'h04));
    start8(3'd6);
    a.cpu_wr = 1'b0;
    #1;
    chk("fill_busy", 32'(a.busy), 1);
    chk("fill_ready", 32'(a.beat_ready), 1);
    chk("fill_cur", 32'(a.cur_word), 6);
    for (int i = 0; i < 8; i++) begin
      a.beat_valid = 1'b1;
      q8.push_back(mk(1'b0, exp2[i]));
      cyc();
    end
    a.beat_valid = 1'b0;
    q8.push_back(mk(1'b1, 8'h00));
    #1;
    chk("done_pulse", 32'(a.fill_done), 1);
    chk("done_busy", 32'(a.busy), 0);
    chk("done_ready", 32'(a.beat_ready), 0);
    chk("done_cur", 32'(a.cur_word), 6);
    cyc();
    chk("done_one_cycle", 32'(a.fill_done), 0);
    cyc();

    // Same fill with toggling beat_valid
    start8(3'd6);
    n = 0;
    t = 1'b1;
    while (n < 8) begin
      a.beat_valid = t;
      if (t) begin
        q8.push_back(mk(1'b0, exp2[n]));
        n++;
      end
      t = !t;
      cyc();
    end
    a.beat_valid = 1'b0;
    q8.push_back(mk(1'b1, 8'h00));
    cyc();
    cyc();

    // Abort after three beats, then a normal fill
    start8(3'd1);
    beats8(3'd1, 3);
    a.abort = 1'b1;
    a.beat_valid = 1'b1;
    #1 chk("abort_en", 32'(a.word_enable), 0);
    cyc();
    a.abort = 1'b0;
    a.beat_valid = 1'b0;
    #1;
    chk("abort_idle", 32'(a.busy), 0);
    chk("abort_ptr_hold", 32'(a.cur_word), 4);
    repeat (3) cyc();
    start8(3'd0);
    beats8(3'd0, 8);
    q8.push_back(mk(1'b1, 8'h00));
    cyc();
    cyc();

    // Reset mid-fill after four beats
    start8(3'd2);
    beats8(3'd2, 4);
    a.beat_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(a.busy), 0);
    chk("rstmid_ready", 32'(a.beat_ready), 0);
    chk("rstmid_cur", 32'(a.cur_word), 0);
    chk("rstmid_en", 32'(a.word_enable), 0);
    a.beat_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // WORDS=4 fill from word 3 with cpu_wr held high throughout
    b.cpu_wr = 1'b1;
    b.cpu_word = 2'd1;
    b.fill_start = 1'b1;
    b.fill_word = 2'd3;
    q4.push_back(mk(1'b0, 8'h02));
    cyc();
    b.fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.beat_valid = 1'b1;
      q4.push_back(mk(1'b0, 8'(exp4[i])));
      cyc();
    end
    b.beat_valid = 1'b0;
    q4.push_back(mk(1'b1, 8'h00));
    #1 chk("w4_done_en", 32'(b.word_enable), 0);
    cyc();
    q4.push_back(mk(1'b0, 8'h02));
    cyc();
    b.cpu_wr = 1'b0;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && (q8.size() != 0 || q4.size() != 0); i++) cyc();
    chk("q8_drain", 32'(q8.size()), 0);
    chk("q4_drain", 32'(q4.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_line_fill_word_sequencer
